// File: rtl/div_ctrl_pkg.sv
// Shared types and constants for the EX-stage divider sequencer.
package div_ctrl_pkg;

   localparam int unsigned DATA_W     = 32;
   localparam int unsigned CNT_W      = 6;
   localparam int unsigned DIV_CYCLES = 32;

   localparam logic [DATA_W-1:0] DIV_ZERO_QUOT = '1;

   typedef enum logic [1:0] {
      DIV_IDLE = 2'd0,
      DIV_ZERO = 2'd1,
      DIV_RUN  = 2'd2,
      DIV_DONE = 2'd3
   } div_state_e;

   // Operation context captured at start
   typedef struct packed {
      logic sgn;
      logic dvd_neg;
      logic dsr_neg;
   } div_op_t;

   function automatic logic [DATA_W-1:0] cond_neg(input logic [DATA_W-1:0] x,
                                                  input logic              neg);
      return neg ? DATA_W'(-x) : x;
   endfunction

endpackage

// File: rtl/div_ctrl_if.sv
// EX-stage <-> divider handshake and result bus.
interface div_ctrl_if;
   import div_ctrl_pkg::*;

   logic              start;
   logic              signed_op;
   logic [DATA_W-1:0] dividend;
   logic [DATA_W-1:0] divisor;
   logic              cancel;
   logic              stall_req;
   logic              busy;
   logic              done;
   logic [DATA_W-1:0] quotient;
   logic [DATA_W-1:0] remainder;

   modport master (
      output start, signed_op, dividend, divisor, cancel,
      input  stall_req, busy, done, quotient, remainder
   );

   modport slave (
      input  start, signed_op, dividend, divisor, cancel,
      output stall_req, busy, done, quotient, remainder
   );

endinterface

// File: rtl/div_step.sv
// One restoring shift-subtract iteration on {rem, quo}.
module div_step
   import div_ctrl_pkg::*;
(
   input  logic [DATA_W-1:0] rem,
   input  logic [DATA_W-1:0] quo,
   input  logic [DATA_W-1:0] divisor,
   output logic [DATA_W-1:0] rem_nxt,
   output logic [DATA_W-1:0] quo_nxt
);

   logic [DATA_W:0] shifted;
   logic            fits;

   // Shifted remainder needs one extra bit before the trial subtract
   always_comb begin
      shifted = {rem, quo[DATA_W-1]};
      fits    = shifted >= {1'b0, divisor};
      if (fits) begin
         rem_nxt = DATA_W'(shifted - {1'b0, divisor});
         quo_nxt = {quo[DATA_W-2:0], 1'b1};
      end else begin
         rem_nxt = shifted[DATA_W-1:0];
         quo_nxt = {quo[DATA_W-2:0], 1'b0};
      end
   end

endmodule

// File: rtl/div_ctrl.sv
// Multi-cycle DIV/DIVU sequencer: operand capture, 32 restoring steps,
// sign correction and pipeline stall/cancel handling.
module div_ctrl
   import div_ctrl_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   div_ctrl_if.slave  bus
);

   div_state_e        state_q, state_nxt;
   logic [CNT_W-1:0]  cnt_q;
   logic [DATA_W-1:0] rem_q, quo_q, dsr_q;
   logic [DATA_W-1:0] step_rem, step_quo;
   logic [DATA_W-1:0] quotient_q, remainder_q;
   div_op_t           op_q, op_in;
   logic              accept, last_step, quo_neg, rem_neg;
   logic              stall_req_c, busy_c, done_c;

   assign accept    = (state_q == DIV_IDLE) && bus.start && !bus.cancel;
   assign last_step = (cnt_q == CNT_W'(DIV_CYCLES - 1));

   assign op_in.sgn     = bus.signed_op;
   assign op_in.dvd_neg = bus.signed_op & bus.dividend[DATA_W-1];
   assign op_in.dsr_neg = bus.signed_op & bus.divisor[DATA_W-1];

   assign quo_neg = op_q.sgn & (op_q.dvd_neg ^ op_q.dsr_neg);
   assign rem_neg = op_q.sgn & op_q.dvd_neg;

   div_step u_step (
      .rem     (rem_q),
      .quo     (quo_q),
      .divisor (dsr_q),
      .rem_nxt (step_rem),
      .quo_nxt (step_quo)
   );

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= DIV_IDLE;
      else      state_q <= state_nxt;
   end

   // Next-state logic; cancel wins from every state
   always_comb begin
      state_nxt = state_q;
      if (bus.cancel) begin
         state_nxt = DIV_IDLE;
      end else begin
         unique case (state_q)
            DIV_IDLE: if (bus.start) state_nxt = (bus.divisor == '0) ? DIV_ZERO : DIV_RUN;
            DIV_ZERO: state_nxt = DIV_DONE;
            DIV_RUN:  if (last_step) state_nxt = DIV_DONE;
            DIV_DONE: state_nxt = DIV_IDLE;
            default:  state_nxt = DIV_IDLE;
         endcase
      end
   end

   // Status outputs decoded from state; stall_req also covers the start cycle
   always_comb begin
      stall_req_c = 1'b0;
      busy_c      = 1'b0;
      done_c      = 1'b0;
      unique case (state_q)
         DIV_IDLE: stall_req_c = bus.start & ~bus.cancel;
         DIV_ZERO,
         DIV_RUN: begin
            stall_req_c = 1'b1;
            busy_c      = 1'b1;
         end
         DIV_DONE: begin
            busy_c = 1'b1;
            done_c = 1'b1;
         end
         default: ;
      endcase
   end

   // Operand capture and iteration datapath
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         op_q  <= '0;
         rem_q <= '0;
         quo_q <= '0;
         dsr_q <= '0;
         cnt_q <= '0;
      end else if (accept) begin
         op_q  <= op_in;
         rem_q <= '0;
         quo_q <= cond_neg(bus.dividend, op_in.dvd_neg);
         dsr_q <= cond_neg(bus.divisor, op_in.dsr_neg);
         cnt_q <= '0;
      end else if (state_q == DIV_RUN) begin
         rem_q <= step_rem;
         quo_q <= step_quo;
         if (cnt_q != CNT_W'(DATA_W)) cnt_q <= cnt_q + CNT_W'(1);
      end
   end

   // Result registers; only a completed operation updates them
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         quotient_q  <= '0;
         remainder_q <= '0;
      end else if (state_nxt == DIV_DONE) begin
         if (state_q == DIV_RUN) begin
            quotient_q  <= cond_neg(step_quo, quo_neg);
            remainder_q <= cond_neg(step_rem, rem_neg);
         end else if (state_q == DIV_ZERO) begin
            // quo_q still holds |dividend|; undo the magnitude to recover the raw value
            quotient_q  <= DIV_ZERO_QUOT;
            remainder_q <= cond_neg(quo_q, op_q.dvd_neg);
         end
      end
   end

   assign bus.stall_req = stall_req_c;
   assign bus.busy      = busy_c;
   assign bus.done      = done_c;
   assign bus.quotient  = quotient_q;
   assign bus.remainder = remainder_q;

endmodule

// File: tb/tb_div_ctrl.sv
// Directed scoreboard bench for div_ctrl.
module tb_div_ctrl;
   import div_ctrl_pkg::*;

   typedef struct packed {
      logic [31:0] q;
      logic [31:0] r;
      logic [7:0]  lat;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   int   n_assert = 0;
   int   n_fail   = 0;
   exp_t scb[$];
   logic [31:0] last_q = '0;
   logic [31:0] last_r = '0;

   always #5 clk = ~clk;

   div_ctrl_if bus ();

   div_ctrl dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference via 64-bit arithmetic: truncating divide, remainder follows dividend
   function automatic exp_t model(input logic sgn, input logic [31:0] a, input logic [31:0] b);
      exp_t m;
      logic signed [63:0] sa, sd, q, r;
      if (b == 32'd0) begin
         m.q   = 32'hFFFF_FFFF;
         m.r   = a;
         m.lat = 8'd2;
      end else begin
         sa    = {{32{sgn & a[31]}}, a};
         sd    = {{32{sgn & b[31]}}, b};
         q     = sa / sd;
         r     = sa % sd;
         m.q   = q[31:0];
         m.r   = r[31:0];
         m.lat = 8'd33;
      end
      return m;
   endfunction

   // Start one division; optionally pulse start again at cycle offset poke
   task automatic run_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                          input int poke);
      exp_t e;
      bit   got;
      bit   stall_ok;
      scb.push_back(model(sgn, a, b));
      @(posedge clk); #1;
      bus.start     = 1'b1;
      bus.signed_op = sgn;
      bus.dividend  = a;
      bus.divisor   = b;
      @(negedge clk);
      chk("stall_at_start", 32'(bus.stall_req), 32'd1);
      got      = 1'b0;
      stall_ok = 1'b1;
      for (int c = 1; c <= 60 && !got; c++) begin
         @(posedge clk); #1;
         bus.start = (c == poke);
         if (c == poke) begin
            bus.dividend  = ~a;
            bus.divisor   = 32'd3;
            bus.signed_op = ~sgn;
         end
         @(negedge clk);
         if (bus.done) begin
            got = 1'b1;
            if (scb.size() == 0) begin
               chk("scoreboard_empty", 32'(scb.size()), 32'd1);
            end else begin
               e = scb.pop_front();
               chk("quotient", bus.quotient, e.q);
               chk("remainder", bus.remainder, e.r);
               chk("done_latency", 32'(c), 32'(e.lat));
               last_q = e.q;
               last_r = e.r;
            end
            chk("stall_in_done", 32'(bus.stall_req), 32'd0);
         end else if (!bus.stall_req || !bus.busy) begin
            stall_ok = 1'b0;
         end
      end
      chk("done_seen", 32'(got), 32'd1);
      if (!got) scb.delete();
      chk("stall_while_running", 32'(stall_ok), 32'd1);
      @(posedge clk); #1;
      bus.start = 1'b0;
      @(negedge clk);
      chk("busy_after_done", 32'(bus.busy), 32'd0);
      chk("done_after_done", 32'(bus.done), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst           = 1'b0;
      bus.start     = 1'b0;
      bus.signed_op = 1'b0;
      bus.dividend  = '0;
      bus.divisor   = '0;
      bus.cancel    = 1'b0;
      #12;
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_done", 32'(bus.done), 32'd0);
      chk("rst_stall", 32'(bus.stall_req), 32'd0);
      chk("rst_quotient", bus.quotient, 32'd0);
      chk("rst_remainder", bus.remainder, 32'd0);
      @(negedge clk);
      rst = 1'b1;

      run_div(1'b0, 32'd100, 32'd7, 0);
      run_div(1'b1, 32'hFFFF_FFF9, 32'd2, 0);
      run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0);
      run_div(1'b0, 32'h0000_1234, 32'd0, 0);
      run_div(1'b1, 32'hFFFF_FF00, 32'd0, 0);
      run_div(1'b1, 32'd100, 32'hFFFF_FFF9, 0);

      // Cancel at T+10, then a fresh start at T+12
      @(posedge clk); #1;
      bus.start = 1'b1; bus.signed_op = 1'b0; bus.dividend = 32'd100; bus.divisor = 32'd7;
      @(posedge clk); #1;
      bus.start = 1'b0;
      repeat (9) @(posedge clk);
      #1 bus.cancel = 1'b1;
      @(negedge clk);
      chk("cancel_cycle_done", 32'(bus.done), 32'd0);
      @(posedge clk); #1;
      bus.cancel = 1'b0;
      @(negedge clk);
      chk("cancel_busy", 32'(bus.busy), 32'd0);
      chk("cancel_no_done", 32'(bus.done), 32'd0);
      chk("cancel_keeps_quotient", bus.quotient, last_q);
      chk("cancel_keeps_remainder", bus.remainder, last_r);
      run_div(1'b0, 32'd9, 32'd3, 0);

      // Start pulsed while running, and in the DONE cycle
      run_div(1'b0, 32'd100, 32'd7, 5);
      run_div(1'b1, 32'hFFFF_FFF9, 32'd2, 33);

      for (int i = 0; i < 4; i++) begin
         run_div(i[0], $urandom, 32'($urandom_range(1, 100000)), 0);
      end

      // Asynchronous reset in the middle of RUN
      @(posedge clk); #1;
      bus.start = 1'b1; bus.signed_op = 1'b0; bus.dividend = 32'd1000; bus.divisor = 32'd7;
      @(posedge clk); #1;
      bus.start = 1'b0;
      repeat (5) @(posedge clk);
      #3 rst = 1'b0;
      #1;
      chk("midrun_rst_busy", 32'(bus.busy), 32'd0);
      chk("midrun_rst_done", 32'(bus.done), 32'd0);
      chk("midrun_rst_stall", 32'(bus.stall_req), 32'd0);
      chk("midrun_rst_quotient", bus.quotient, 32'd0);
      chk("midrun_rst_remainder", bus.remainder, 32'd0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("post_rst_idle", 32'(bus.busy), 32'd0);
      run_div(1'b0, 32'd100, 32'd7, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
